divn_pipe_ctl: RTL and testbench

//   Parametrised iterative integer divider; next generation of the core's fixed 32-bit divider.
//   - Serves the RISC-V M-extension DIV/DIVU/REM/REMU path in the execute stage.
//   - Adds configurable width and bits-per-cycle, plus valid/ready handshakes on both sides.
//   - Returns RISC-V results for divide-by-zero and signed overflow without iterating.

---
 rtl/divn_pipe_ctl_if.sv | 27 ++
 rtl/divn_pipe_ctl.sv | 126 ++++++++++++
 tb/tb_divn_pipe_ctl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divn_pipe_ctl_if.sv
// Request/response bundle for the iterative divider: operand handshake in,
// result handshake out, plus status.
interface divn_pipe_ctl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             signed_div;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, signed_div, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, signed_div, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/divn_pipe_ctl.sv
// Iterative restoring divider with RISC-V DIV/DIVU/REM/REMU semantics,
// BPC quotient bits per cycle and valid/ready on both sides.
module divn_pipe_ctl #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic           clk,
  input logic           reset_n,
  divn_pipe_ctl_if.slave bus
);
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;        // shifts dividend bits out, quotient bits in
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] quot_out, rem_out;
  logic             dz_out;

  logic             accept;
  logic             sign_a, sign_b, is_zero, is_ovf;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   r_nxt, r_sh;
  logic [WIDTH-1:0] a_nxt;

  assign bus.in_ready    = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.quotient    = quot_out;
  assign bus.remainder   = rem_out;
  assign bus.div_by_zero = dz_out;

  assign accept  = bus.in_valid && bus.in_ready;
  assign sign_a  = bus.signed_div && bus.dividend[WIDTH-1];
  assign sign_b  = bus.signed_div && bus.divisor[WIDTH-1];
  assign abs_a   = sign_a ? -bus.dividend : bus.dividend;
  assign abs_b   = sign_b ? -bus.divisor  : bus.divisor;
  assign is_zero = (bus.divisor == '0);
  assign is_ovf  = bus.signed_div && (bus.dividend == MIN_VAL) && (bus.divisor == '1);

  // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
  always_comb begin
    r_nxt = rem_q;
    a_nxt = a_q;
    r_sh  = '0;
    // NOTE: blocking assignments here chain the BPC steps within one cycle.
    for (int i = 0; i < BPC; i++) begin
      r_sh  = {r_nxt[WIDTH-1:0], a_nxt[WIDTH-1]};
      a_nxt = {a_nxt[WIDTH-2:0], 1'b0};
      if (r_sh >= {1'b0, b_q}) begin
        r_nxt    = r_sh - {1'b0, b_q};
        a_nxt[0] = 1'b1;
      end else begin
        r_nxt = r_sh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      quot_out <= '0;
      rem_out  <= '0;
      dz_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_zero) begin
              quot_out <= '1;
              rem_out  <= bus.dividend;
              dz_out   <= 1'b1;
              state    <= S_DONE;
            end else if (is_ovf) begin
              quot_out <= MIN_VAL;
              rem_out  <= '0;
              dz_out   <= 1'b0;
              state    <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end else if (state == S_DONE && bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (cnt == CW'(STEPS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          quot_out <= neg_q ? -a_q : a_q;
          rem_out  <= neg_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dz_out   <= 1'b0;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept
  // before being read, and out_valid gates everything visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= abs_a;
      b_q   <= abs_b;
      rem_q <= '0;
      cnt   <= '0;
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
    end else if (state == S_CALC) begin
      a_q   <= a_nxt;
      rem_q <= r_nxt;
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_divn_pipe_ctl.sv
// Scoreboard bench for divn_pipe_ctl: expected results come from plain SV
// division with the RISC-V special-case rules, checked by a separate monitor.
module tb_divn_pipe_ctl;
  localparam int W     = 32;
  localparam int BPC   = 1;
  localparam int STEPS = W / BPC;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         s, dz;
    int           lat, acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_pass = 0, n_tot = 0;
  exp_t sb[$];
  bit   presented = 0;
  bit   rnd_rdy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divn_pipe_ctl_if #(.WIDTH(W)) bus ();
  divn_pipe_ctl_if #(.WIDTH(W)) bus2 ();

  divn_pipe_ctl #(.WIDTH(W), .BPC(BPC)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  divn_pipe_ctl #(.WIDTH(W), .BPC(2))   u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic signed [W-1:0] sa, sbv;
    e.a = a; e.b = b; e.s = s; e.acc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (s && a == MIN && b == '1) begin
      e.q = MIN; e.r = '0; e.dz = 1'b0; e.lat = 1;
    end else begin
      if (s) begin
        sa = a; sbv = b;
        e.q = sa / sbv;
        e.r = sa % sbv;
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
      e.dz = 1'b0; e.lat = STEPS + 2;
    end
    return e;
  endfunction

  // Called right after a negedge; returns right after the negedge following accept.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      output int tries);
    exp_t e;
    tries = 0;
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b; bus.signed_div = s;
    forever begin
      tries++;
      #1;
      if (bus.in_ready) begin
        e = model(a, b, s);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      if (tries > 200) begin
        check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !bus.out_valid) return;
      @(negedge clk);
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: compare when a result is first presented, pop when it retires.
  always begin
    @(negedge clk);
    #2;
    if (reset_n && bus.out_valid) begin
      if (!presented) begin
        presented = 1;
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          exp_t e;
          logic [W-1:0] inv;
          e = sb[0];
          check("quotient", 64'(bus.quotient), 64'(e.q));
          check("remainder", 64'(bus.remainder), 64'(e.r));
          check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dz));
          check("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
          if (e.b != '0) begin
            inv = bus.quotient * e.b + bus.remainder;
            check("invariant", 64'(inv), 64'(e.a));
          end
        end
      end
      if (bus.out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        presented = 0;
      end
    end
  end

  always @(negedge clk) if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));

  initial begin
    int tries, acc2, lat2, seen;
    logic [W-1:0] a, b;
    logic s;

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0;
    bus.signed_div = 1'b0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.dividend = '0; bus2.divisor = '0;
    bus2.signed_div = 1'b0; bus2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_dz", 64'(bus.div_by_zero), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases, some issued back-to-back
    send(W'(7), W'(2), 1'b0, tries); drain();
    send(W'(-7), W'(2), 1'b1, tries);
    send(W'(7), W'(-2), 1'b1, tries); drain();
    send(W'(5), W'(0), 1'b0, tries);
    send(W'(5), W'(0), 1'b1, tries); drain();
    send(MIN, '1, 1'b1, tries);
    send(MIN, '1, 1'b0, tries); drain();

    // Hold result in DONE, then retire and accept on the same edge
    bus.out_ready = 1'b0;
    send(W'(100), W'(7), 1'b0, tries);
    for (int i = 0; i < 60 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_q", 64'(bus.quotient), 64'd14);
      check("hold_r", 64'(bus.remainder), 64'd2);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(W'(13), W'(-4), 1'b1, tries);
    check("back_to_back_accept_tries", 64'(tries), 64'd1);
    drain();

    // Reset in the middle of a calculation
    send(W'(1000), W'(3), 1'b0, tries);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    presented = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    send(W'(100), W'(7), 1'b0, tries); drain();

    // Two-bits-per-cycle instance: 7/2 with shortened latency
    bus2.in_valid = 1'b1; bus2.dividend = W'(7); bus2.divisor = W'(2); bus2.signed_div = 1'b0;
    #1;
    check("bpc2_in_ready", 64'(bus2.in_ready), 64'd1);
    acc2 = cyc + 1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    lat2 = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus2.out_valid) begin lat2 = cyc + 1 - acc2; break; end
      @(negedge clk);
    end
    check("bpc2_latency", 64'(lat2), 64'(W / 2 + 2));
    check("bpc2_q", 64'(bus2.quotient), 64'd3);
    check("bpc2_r", 64'(bus2.remainder), 64'd1);
    @(negedge clk);

    // Random vectors with random consumer back-pressure
    rnd_rdy = 1;
    for (int n = 0; n < 1200; n++) begin
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        3: b = W'($urandom_range(1, 65535));
        default: b = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: a = MIN;
        1: a = W'($urandom_range(0, 255));
        default: a = W'($urandom);
      endcase
      s = 1'($urandom_range(0, 1));
      send(a, b, s, tries);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    @(negedge clk);
    rnd_rdy = 0;
    bus.out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
